alu_hs: RTL and testbench
=========================

# alu_hs

Parametrised, handshaked successor to the single-cycle sequential ALU in the verification testbench DUT set. Signed ADD/SUB/MULT complete in one cycle. DIV runs on an iterative multi-cycle divider. The block adds overflow and divide-by-zero flags, optional saturation, and valid/ready flow control on both sides. It sits between a stimulus driver and a scoreboard and is the next target for the constrained-random environment.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 4); all data signed two's complement
- SAT, 0, 0 = wrap results to WIDTH bits, 1 = clamp to signed max/min on overflow

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept (combinational from state/output register)
- operand1  in  WIDTH  signed first operand
- operand2  in  WIDTH  signed second operand
- opcode  in  opcode_e  ADD, SUB, MULT, DIV
- out_valid  out  1  result held on out/ovf/dz
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  signed result
- ovf  out  1  result not representable in WIDTH (wrapped or clamped)
- dz  out  1  DIV with operand2 == 0

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Operands and opcode are captured.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Transfer out: out_valid && out_ready at a rising edge.
- States:
  - IDLE: accepting.
  - DIV_RUN: divider iterating.
  - Single-entry output register: out/ovf/dz with out_valid.
- ADD/SUB/MULT: full-precision signed result computed.
  - ovf = 1 if the result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - out = low WIDTH bits (SAT=0) or clamped bound (SAT=1).
- DIV, operand2 != 0:
  - IDLE → DIV_RUN. Restoring division on magnitudes, WIDTH iterations, one quotient bit per cycle.
  - Sign is corrected at the end; quotient truncates toward zero.
  - Only min / -1 sets ovf: out = min (SAT=0) or max (SAT=1).
  - Returns to IDLE when the result is written.
- DIV, operand2 == 0: no iteration. out = 0, dz = 1, ovf = 0, one-cycle latency.
- Unused opcode encoding: out = 0, ovf = 0, dz = 0.
- ovf/dz describe the current result only. They are rewritten with every result and are never sticky.
- Output register is stable while out_valid && !out_ready.

## Timing
- Reset (rst=1 at an edge):
  - state = IDLE; out_valid = 0, out = 0, ovf = 0, dz = 0; divider cleared.
  - in_ready = 1 in the first cycle after rst deasserts.
- Reset mid-DIV_RUN: the operation is abandoned and no result is ever presented.
- Non-DIV accepted at edge T: out_valid = 1 after edge T+1.
- DIV accepted at edge T: in_ready = 0 for cycles T+1..T+WIDTH; out_valid = 1 after edge T+WIDTH+1.
- Throughput: one non-DIV op per cycle when out_ready = 1.
  - Output drain and new acceptance may occur in the same edge.
  - The result register is overwritten with no gap.
- Backpressure: out_valid && !out_ready forces in_ready = 0; no input is lost.
- in_valid with in_ready = 0 has no effect. The driver holds its values.

## Structure
- testing_pkg:
  - keeps opcode_e (ADD, SUB, MULT, DIV)
  - adds alu_state_e (IDLE, DIV_RUN)
  - adds functions sat_max(WIDTH) and sat_min(WIDTH) used by RTL and scoreboard
- Sub-module alu_div_iter: start/busy/done interface; WIDTH-bit signed dividend and divisor; quotient plus ovf out.
- Top handles the handshake, the single-cycle ops and the output register.

## Test plan
- WIDTH=8, SAT=0: ADD 100+50 → out = -106 (0x96), ovf = 1, out_valid one cycle after accept. With SAT=1 → out = 127, ovf = 1.
- MULT -128 × -1 → SAT=0: out = -128, ovf = 1; SAT=1: out = 127, ovf = 1. MULT -3 × 5 → out = -15, ovf = 0.
- DIV -7 / 2 → out = -3, ovf = 0, dz = 0; out_valid exactly 9 edges after accept; in_ready low for 8 cycles. DIV -128 / -1 → ovf = 1.
- DIV 5 / 0 → out = 0, dz = 1, ovf = 0, out_valid after one edge, no DIV_RUN entry.
- Backpressure with 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4):
  - out_ready = 0 for cycles 2–4 → out holds 2 and in_ready = 0.
  - Results arrive 2, 4, 6, 8 in order, none dropped or duplicated.
- Reset on the 4th cycle of DIV 100 / 3 → out_valid stays 0; in_ready = 1 after release; a following ADD 1+2 yields out = 3 with no stale 33.

Source files
------------

// File: rtl/testing_pkg.sv
// rtl/testing_pkg.sv - shared opcode/state types and signed saturation bounds for alu_hs
package testing_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MULT = 2'd2,
    DIV  = 2'd3
  } opcode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } alu_state_e;

  // Largest signed value representable in 'width' bits, sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in 'width' bits, sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - iterative signed restoring divider, one quotient bit per cycle
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH-1:0] nxt_rem, nxt_quo;
  logic [WIDTH:0]   trial, diff;
  logic             fits;

  // One restoring step; on start it runs directly on the operand magnitudes so the
  // first quotient bit is produced in the same edge that loads the divider.
  always_comb begin
    mag_a   = dividend[WIDTH-1] ? -dividend : dividend;
    mag_b   = divisor[WIDTH-1]  ? -divisor  : divisor;
    src_rem = start ? '0    : rem_q;
    src_quo = start ? mag_a : quo_q;
    src_dvs = start ? mag_b : dvs_q;
    trial   = {src_rem, src_quo[WIDTH-1]};
    diff    = trial - {1'b0, src_dvs};
    fits    = !diff[WIDTH];
    nxt_rem = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    nxt_quo = {src_quo[WIDTH-2:0], fits};
  end

  assign done     = busy && (cnt_q == CW'(WIDTH));
  assign quotient = neg_q ? -quo_q : quo_q;
  // A positive quotient with the top bit set is +2^(WIDTH-1): only min / -1 gets here.
  assign ovf      = !neg_q && quo_q[WIDTH-1];

  // Iteration registers: load on start, step until all bits are done, release on done.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
    end else if (start) begin
      rem_q <= nxt_rem;
      quo_q <= nxt_quo;
      dvs_q <= mag_b;
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      cnt_q <= CW'(1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        rem_q <= nxt_rem;
        quo_q <= nxt_quo;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_hs.sv
// rtl/alu_hs.sv - handshaked signed ALU with overflow/divide-by-zero flags and optional saturation
module alu_hs
  import testing_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  opcode_e          opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             dz
);

  localparam logic signed [2*WIDTH-1:0] MAX_W = (2*WIDTH)'(sat_max(WIDTH));
  localparam logic signed [2*WIDTH-1:0] MIN_W = (2*WIDTH)'(sat_min(WIDTH));
  localparam logic [WIDTH-1:0]          MAX_N = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0]          MIN_N = WIDTH'(sat_min(WIDTH));

  alu_state_e state_q, state_d;

  logic                      accept, div_start, load;
  logic                      div_busy, div_done, div_ovf;
  logic [WIDTH-1:0]          div_quo;
  logic signed [WIDTH-1:0]   a_s, b_s;
  logic signed [2*WIDTH-1:0] a_w, b_w, res_wide;
  logic                      ovf_alu;
  logic [WIDTH-1:0]          nxt_out;
  logic                      nxt_ovf, nxt_dz;

  assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (opcode == DIV) && (operand2 != '0);
  // Divide-by-zero and all single-cycle ops land in the output register at accept.
  assign load      = (accept && !div_start) || div_done;
  assign a_s       = operand1;
  assign b_s       = operand2;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (operand1),
    .divisor  (operand2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .ovf      (div_ovf)
  );

  // Full-precision result of the single-cycle ops; 2*WIDTH bits holds any product.
  always_comb begin
    a_w      = a_s;
    b_w      = b_s;
    res_wide = '0;
    case (opcode)
      ADD:     res_wide = a_w + b_w;
      SUB:     res_wide = a_w - b_w;
      MULT:    res_wide = a_w * b_w;
      default: res_wide = '0;
    endcase
  end

  assign ovf_alu = (res_wide > MAX_W) || (res_wide < MIN_W);

  // Select what the output register captures: divider result while running, else the new op.
  always_comb begin
    nxt_out = '0;
    nxt_ovf = 1'b0;
    nxt_dz  = 1'b0;
    if (state_q == DIV_RUN) begin
      nxt_ovf = div_ovf;
      nxt_out = (div_ovf && SAT != 0) ? MAX_N : div_quo;
    end else begin
      case (opcode)
        ADD, SUB, MULT: begin
          nxt_ovf = ovf_alu;
          if (ovf_alu && SAT != 0) nxt_out = res_wide[2*WIDTH-1] ? MIN_N : MAX_N;
          else                     nxt_out = res_wide[WIDTH-1:0];
        end
        DIV:     nxt_dz = 1'b1;
        default: nxt_out = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave IDLE only for a real division, return when its result is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_start) state_d = DIV_RUN;
      DIV_RUN: if (div_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-entry output register; a load in the same edge as a drain overwrites with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out       <= nxt_out;
      ovf       <= nxt_ovf;
      dz        <= nxt_dz;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// tb/tb_alu_hs.sv - randomized and directed bench for alu_hs against an arithmetic reference model
module tb_alu_hs;
  import testing_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [W-1:0] operand1, operand2;
  opcode_e      opcode;
  logic         in_ready0, out_valid0, ovf0, dz0;
  logic [W-1:0] out0;
  logic         in_ready1, out_valid1, ovf1, dz1;
  logic [W-1:0] out1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_hs #(.WIDTH(W), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .operand1(operand1), .operand2(operand2), .opcode(opcode),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .ovf(ovf0), .dz(dz0)
  );

  alu_hs #(.WIDTH(W), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .operand1(operand1), .operand2(operand2), .opcode(opcode),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .ovf(ovf1), .dz(dz1)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range test, then wrap or clamp.
  function automatic void model(input opcode_e op, input int a, input int b, input bit sat,
                                output int o, output bit v, output bit z);
    longint              f;
    logic [63:0]         fb;
    logic signed [W-1:0] t;
    f = 0; o = 0; v = 0; z = 0;
    case (op)
      ADD:     f = longint'(a) + longint'(b);
      SUB:     f = longint'(a) - longint'(b);
      MULT:    f = longint'(a) * longint'(b);
      default: if (b == 0) z = 1'b1; else f = longint'(a) / longint'(b);
    endcase
    if (!z) begin
      v  = (f > sat_max(W)) || (f < sat_min(W));
      fb = f;
      t  = fb[W-1:0];
      if (v && sat) o = (f > 0) ? int'(sat_max(W)) : int'(sat_min(W));
      else          o = int'(t);
    end
  endfunction

  task automatic send(input opcode_e op, input int a, input int b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    opcode   = op;
    operand1 = W'(a);
    operand2 = W'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready0) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input opcode_e op, input int a, input int b);
    bit ok, got;
    int lat, irlow, eo0, eo1;
    bit ev0, ez0, ev1, ez1;
    bit slow;
    model(op, a, b, 1'b0, eo0, ev0, ez0);
    model(op, a, b, 1'b1, eo1, ev1, ez1);
    slow = (op == DIV) && (b != 0);
    send(op, a, b, ok);
    if (ok) begin
      lat = 0; irlow = 0; got = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i == 0) in_valid = 1'b0;
        #1;
        lat++;
        if (out_valid0) begin
          got = 1'b1;
          break;
        end
        if (!in_ready0) irlow++;
      end
      check({tag, "_valid"}, got, 1);
      if (got) begin
        check({tag, "_lat"}, lat, slow ? W + 1 : 1);
        check({tag, "_irlow"}, irlow, slow ? W : 0);
        check({tag, "_out"}, $signed(out0), eo0);
        check({tag, "_ovf"}, ovf0, ev0);
        check({tag, "_dz"}, dz0, ez0);
        check({tag, "_sat_valid"}, out_valid1, 1);
        check({tag, "_sat_out"}, $signed(out1), eo1);
        check({tag, "_sat_ovf"}, ovf1, ev1);
        check({tag, "_sat_dz"}, dz1, ez1);
      end
    end
  endtask

  initial begin
    bit      ok, seen, acc_pend, drain_pend;
    int      idx, rec, ra, rb;
    int      q[$];
    opcode_e rop;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = ADD; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid0, 0);
    check("rst_out", out0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_dz", dz0, 0);
    check("rst_sat_out_valid", out_valid1, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready0, 1);

    run_op("add_100_50", ADD, 100, 50);
    run_op("sub_m100_50", SUB, -100, 50);
    run_op("sub_50_m100", SUB, 50, -100);
    run_op("mult_m128_m1", MULT, -128, -1);
    run_op("mult_m3_5", MULT, -3, 5);
    run_op("mult_m128_127", MULT, -128, 127);
    run_op("div_m7_2", DIV, -7, 2);
    run_op("div_m128_m1", DIV, -128, -1);
    run_op("div_m128_1", DIV, -128, 1);
    run_op("div_5_0", DIV, 5, 0);
    run_op("div_127_m128", DIV, 127, -128);
    run_op("add_m128_m1", ADD, -128, -1);

    for (int n = 0; n < 80; n++) begin
      rop = opcode_e'($urandom_range(0, 3));
      ra  = int'($urandom_range(0, 255)) - 128;
      rb  = int'($urandom_range(0, 255)) - 128;
      if (rop == DIV && $urandom_range(0, 7) == 0) rb = 0;
      run_op("rand", rop, ra, rb);
    end

    // Four back-to-back ADDs with the consumer stalled in cycles 2-4.
    idx = 0; acc_pend = 0; drain_pend = 0; rec = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (acc_pend) idx++;
      if (drain_pend) q.push_back(rec);
      out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      in_valid  = (idx < 4);
      opcode    = ADD;
      operand1  = W'(idx + 1);
      operand2  = W'(idx + 1);
      #1;
      if (c >= 2 && c <= 4) begin
        check("bp_hold_valid", out_valid0, 1);
        check("bp_hold_out", $signed(out0), 2);
        check("bp_in_ready", in_ready0, 0);
      end
      acc_pend   = in_valid && in_ready0;
      drain_pend = out_valid0 && out_ready;
      rec        = int'($signed(out0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q.size()) check("bp_order", q[i], 2 * (i + 1));

    // Reset during the 4th cycle of a division abandons it.
    send(DIV, 100, 3, ok);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rdiv_in_ready", in_ready0, 1);
    check("rdiv_out", out0, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    check("rdiv_no_result", seen, 0);
    run_op("add_after_rst", ADD, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
